// File: rtl/asa_pio_bridge.sv
// Host-facing PIO master for the ASA register block.
// Decodes the address window, drives one register transaction at a time,
// waits for the block's sticky ack/rvalid (with a timeout), and then drains
// those sticky flags before the next host request is accepted.
module asa_pio_bridge #(
    parameter int                   PIO_NBITS      = 32,
    parameter int                   REG_ADDR_NBITS = 8,
    parameter logic [PIO_NBITS-1:0] BASE_ADDR      = 32'h0000_0400,
    parameter int                   DIV            = 4,
    parameter int                   TIMEOUT        = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 host_req_valid,
    output logic                 host_req_ready,
    input  logic                 host_req_wr,
    input  logic [PIO_NBITS-1:0] host_req_addr,
    input  logic [PIO_NBITS-1:0] host_req_wdata,
    output logic                 host_rsp_valid,
    output logic                 host_rsp_err,
    output logic [PIO_NBITS-1:0] host_rsp_rdata,
    output logic                 clk_div,
    output logic                 reg_bs,
    output logic                 reg_rd,
    output logic                 reg_wr,
    output logic [PIO_NBITS-1:0] reg_addr,
    output logic [PIO_NBITS-1:0] reg_din,
    input  logic                 pio_ack,
    input  logic                 pio_rvalid,
    input  logic [PIO_NBITS-1:0] pio_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERR   = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam int               DIV_W    = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    // The WAIT cycle that sees the counter at TIMEOUT-1 is the TIMEOUT-th one.
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       tmo_cnt;
    logic             wr_q;
    logic             win_hit;
    logic             done;

    assign win_hit = (host_req_addr[PIO_NBITS-1:REG_ADDR_NBITS]
                      == BASE_ADDR[PIO_NBITS-1:REG_ADDR_NBITS]);
    // A write only listens to ack, a read only to rvalid.
    assign done    = wr_q ? pio_ack : pio_rvalid;

    // Free-running enable for the register block, one pulse every DIV clocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            clk_div <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            clk_div <= 1'b0;
        end
    end

    // Transaction FSM; every output is registered and updated with the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            tmo_cnt        <= '0;
            wr_q           <= 1'b0;
            host_req_ready <= 1'b0;
            host_rsp_valid <= 1'b0;
            host_rsp_err   <= 1'b0;
            host_rsp_rdata <= '0;
            reg_bs         <= 1'b0;
            reg_rd         <= 1'b0;
            reg_wr         <= 1'b0;
            reg_addr       <= '0;
            reg_din        <= '0;
        end else begin
            // NOTE: pulses are defaulted low here and raised below; with
            // non-blocking assignments the last write in the block wins, so
            // each strobe lasts exactly the one cycle it is set for.
            host_rsp_valid <= 1'b0;
            host_rsp_err   <= 1'b0;
            reg_rd         <= 1'b0;
            reg_wr         <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ready tracks the state register, so it is raised on the
                    // same edge that enters IDLE and dropped on acceptance.
                    if (host_req_valid && host_req_ready) begin
                        host_req_ready <= 1'b0;
                        reg_addr       <= host_req_addr;
                        reg_din        <= host_req_wdata;
                        wr_q           <= host_req_wr;
                        if (win_hit) begin
                            state  <= S_REQ;
                            reg_bs <= 1'b1;
                            reg_wr <= host_req_wr;
                            reg_rd <= ~host_req_wr;
                        end else begin
                            state <= S_ERR;
                        end
                    end else begin
                        host_req_ready <= 1'b1;
                    end
                end
                S_ERR: begin
                    host_rsp_valid <= 1'b1;
                    host_rsp_err   <= 1'b1;
                    host_rsp_rdata <= '0;
                    host_req_ready <= 1'b1;
                    state          <= S_IDLE;
                end
                S_REQ: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        host_rsp_valid <= 1'b1;
                        host_rsp_rdata <= wr_q ? '0 : pio_rdata;
                        reg_bs         <= 1'b0;
                        state          <= S_DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        host_rsp_valid <= 1'b1;
                        host_rsp_err   <= 1'b1;
                        host_rsp_rdata <= '0;
                        reg_bs         <= 1'b0;
                        state          <= S_DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Sticky flags from the finished access must be gone
                    // before a new request may be accepted.
                    if (!pio_ack && !pio_rvalid) begin
                        host_req_ready <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    reg_bs         <= 1'b0;
                    host_req_ready <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asa_pio_bridge.sv
// Self-checking bench for asa_pio_bridge: a register-block stub answers the
// strobes on clk_div with sticky ack/rvalid, and a scoreboard predicts every
// host response from the address window and a reference memory.
module tb_asa_pio_bridge;

    localparam int          NB   = 32;
    localparam int          RA   = 8;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam int          DIV  = 4;
    localparam int          TMO  = 16;

    logic        clk;
    logic        rstn;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_wr;
    logic [31:0] host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_rsp_valid;
    logic        host_rsp_err;
    logic [31:0] host_rsp_rdata;
    logic        clk_div;
    logic        reg_bs;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_addr;
    logic [31:0] reg_din;
    logic        pio_ack;
    logic        pio_rvalid;
    logic [31:0] pio_rdata;

    asa_pio_bridge #(
        .PIO_NBITS     (NB),
        .REG_ADDR_NBITS(RA),
        .BASE_ADDR     (BASE),
        .DIV           (DIV),
        .TIMEOUT       (TMO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .host_req_valid(host_req_valid),
        .host_req_ready(host_req_ready),
        .host_req_wr   (host_req_wr),
        .host_req_addr (host_req_addr),
        .host_req_wdata(host_req_wdata),
        .host_rsp_valid(host_rsp_valid),
        .host_rsp_err  (host_rsp_err),
        .host_rsp_rdata(host_rsp_rdata),
        .clk_div       (clk_div),
        .reg_bs        (reg_bs),
        .reg_rd        (reg_rd),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_din       (reg_din),
        .pio_ack       (pio_ack),
        .pio_rvalid    (pio_rvalid),
        .pio_rdata     (pio_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc_cyc;
    } exp_t;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_acc   = 0;
    int          n_rsp   = 0;
    int          n_strobe = 0;
    int          bs_cnt  = 0;
    int          last_lat = 0;
    logic        last_acc = 1'b0;
    logic [31:0] last_exp_rdata = '0;
    logic [31:0] strobe_din  = '0;
    logic [31:0] strobe_addr = '0;
    logic        strobe_wr   = 1'b0;
    exp_t        exp_q[$];

    // reference memory (model) and the stub's own register storage
    logic [31:0] model_mem [256];
    logic [31:0] stub_mem  [256];
    logic        silent   = 1'b0;
    logic        pend     = 1'b0;
    logic        pend_wr  = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_din  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected host response for one accepted request.
    function automatic exp_t predict(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic sil);
        exp_t e;
        e.acc_cyc = 0;
        if ((addr >> RA) != (BASE >> RA) || sil) begin
            e.err   = 1'b1;
            e.rdata = '0;
        end else if (wr) begin
            model_mem[addr[7:0]] = wd;
            e.err   = 1'b0;
            e.rdata = '0;
        end else begin
            e.err   = 1'b0;
            e.rdata = model_mem[addr[7:0]];
        end
        return e;
    endfunction

    // One clock: snapshot what the DUT drives now, advance, run stub and scoreboard.
    task automatic tick();
        logic        s_wr, s_rd, s_div, s_ack, s_rv, s_ready, s_bs, s_rspv, s_acc, s_hwr;
        logic [31:0] s_addr, s_din, s_haddr, s_hwd;
        int          c0;
        exp_t        e;
        s_wr = reg_wr;   s_rd = reg_rd;   s_div = clk_div;  s_ack = pio_ack;
        s_rv = pio_rvalid; s_ready = host_req_ready; s_bs = reg_bs;
        s_rspv = host_rsp_valid; s_addr = reg_addr; s_din = reg_din;
        s_acc = host_req_valid && host_req_ready && rstn;
        s_hwr = host_req_wr; s_haddr = host_req_addr; s_hwd = host_req_wdata;
        c0 = cyc;
        @(posedge clk);
        #1;
        cyc++;

        // register-block stub: acts on clk_div, flags sticky until the next one
        if (!silent && (s_wr || s_rd)) begin
            pend = 1'b1; pend_wr = s_wr; pend_addr = s_addr; pend_din = s_din;
        end
        if (s_div) begin
            if (pio_ack || pio_rvalid) begin
                pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = $urandom;
            end else if (pend) begin
                pend = 1'b0;
                if (pend_wr) begin
                    stub_mem[pend_addr[7:0]] = pend_din;
                    pio_ack = 1'b1;
                end else begin
                    pio_rdata  = stub_mem[pend_addr[7:0]];
                    pio_rvalid = 1'b1;
                end
            end
        end

        // scoreboard
        last_acc = s_acc;
        if (s_acc) begin
            check("accept_ack_clear", 32'(s_ack | s_rv), 32'd0);
            e = predict(s_hwr, s_haddr, s_hwd, silent);
            e.acc_cyc = c0;
            exp_q.push_back(e);
            n_acc++;
        end
        if (host_rsp_valid) begin
            n_rsp++;
            check("rsp_has_req", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_err", 32'(host_rsp_err), 32'(e.err));
                check("rsp_rdata", host_rsp_rdata, e.rdata);
                last_lat = cyc - e.acc_cyc;
                last_exp_rdata = e.rdata;
            end
        end
        if (s_rspv && !host_rsp_valid && rstn)
            check("rdata_hold", host_rsp_rdata, last_exp_rdata);
        if (reg_wr || reg_rd) begin
            n_strobe++;
            check("strobe_bs", 32'(reg_bs), 32'd1);
            check("strobe_one_cycle", 32'(s_wr | s_rd), 32'd0);
            strobe_din = reg_din; strobe_addr = reg_addr; strobe_wr = reg_wr;
        end
        if (reg_bs) bs_cnt++;
        if (reg_bs && s_bs) begin
            check("addr_stable", reg_addr, s_addr);
            check("din_stable", reg_din, s_din);
        end
        if (host_req_ready && !s_ready && rstn)
            check("ready_after_drain", 32'(s_ack | s_rv), 32'd0);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        host_req_wr = wr; host_req_addr = addr; host_req_wdata = wd;
        host_req_valid = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 200 && !last_acc; i++) tick();
        check("accept_bound", 32'(last_acc), 32'd1);
        host_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 200 && n_rsp < target; i++) tick();
        check("rsp_bound", n_rsp, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !host_req_ready; i++) tick();
        check("idle_bound", 32'(host_req_ready), 32'd1);
    endtask

    function automatic logic [31:0] outs_all();
        return {25'd0, host_req_ready, host_rsp_valid, host_rsp_err, clk_div,
                reg_bs, reg_rd, reg_wr} | host_rsp_rdata | reg_addr | reg_din;
    endfunction

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            stub_mem[i]  = '0;
        end
        host_req_valid = 1'b0; host_req_wr = 1'b0;
        host_req_addr = '0; host_req_wdata = '0;
        pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("reset_outputs", outs_all(), 32'd0);
        repeat (3) tick();
        check("reset_held_outputs", outs_all(), 32'd0);

        // release: ready one cycle later, first clk_div DIV cycles later
        rstn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check("ready_after_release", 32'(host_req_ready), 32'd1);
        end while (!clk_div && n < 50);
        check("first_div", n, DIV);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin tick(); n++; end while (!clk_div && n < 50);
            check("div_period", n, DIV);
        end

        // write 0x1234 to BASE+0
        r0 = n_rsp; n = n_strobe;
        issue(1'b1, BASE, 32'h0000_1234);
        wait_rsp(r0 + 1);
        check("wr_strobe_count", n_strobe, n + 1);
        check("wr_strobe_kind", 32'(strobe_wr), 32'd1);
        check("wr_strobe_din", strobe_din, 32'h0000_1234);
        check("wr_strobe_addr", strobe_addr, BASE);
        check("wr_latency", 32'(last_lat <= DIV + 3), 32'd1);
        wait_idle();

        // read BASE+0 back
        r0 = n_rsp; bs_cnt = 0;
        issue(1'b0, BASE, $urandom);
        wait_rsp(r0 + 1);
        check("rd_strobe_kind", 32'(strobe_wr), 32'd0);
        check("rd_bs_hold", bs_cnt, last_lat - 1);
        wait_idle();

        // out-of-window write: error, no strobes, two cycles after acceptance
        r0 = n_rsp; bs_cnt = 0; n = n_strobe;
        issue(1'b1, 32'h0000_0800, 32'hDEAD_BEEF);
        wait_rsp(r0 + 1);
        check("oow_latency", last_lat, 2);
        wait_idle();
        check("oow_no_bs", bs_cnt, 0);
        check("oow_no_strobe", n_strobe, n);

        // silent register block: timeout after TMO WAIT cycles
        silent = 1'b1;
        r0 = n_rsp; bs_cnt = 0;
        issue(1'b0, BASE + 32'h4, '0);
        wait_rsp(r0 + 1);
        check("tmo_latency", last_lat, TMO + 2);
        check("tmo_bs_cycles", bs_cnt, TMO + 1);
        wait_idle();
        silent = 1'b0;

        // back-to-back write then read with valid held throughout
        r0 = n_rsp;
        a = BASE + 32'h10;
        issue(1'b1, a, 32'hA5A5_0F0F);
        issue(1'b0, a, '0);
        issue(1'b1, a + 32'h4, 32'h1357_9BDF);
        issue(1'b1, a + 32'h8, 32'h0246_8ACE);
        issue(1'b0, a + 32'h4, '0);
        wait_rsp(r0 + 5);
        wait_idle();
        check("b2b_one_rsp_each", n_rsp, n_acc);

        // randomized traffic, mostly inside the window
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(9) < 8) a = BASE + 32'($urandom_range(255));
            else a = $urandom;
            issue(1'($urandom_range(1)), a, $urandom);
            repeat ($urandom_range(3)) tick();
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        check("random_drained", exp_q.size(), 0);
        wait_idle();
        check("random_one_rsp_each", n_rsp, n_acc);

        // reset while in WAIT: everything clears at once, no response later
        silent = 1'b1;
        issue(1'b0, BASE + 32'h20, '0);
        tick();
        check("pre_reset_bs", 32'(reg_bs), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_reset_outputs", outs_all(), 32'd0);
        exp_q.delete();
        pend = 1'b0; pio_ack = 1'b0; pio_rvalid = 1'b0;
        last_exp_rdata = '0;
        silent = 1'b0;
        repeat (2) tick();
        r0 = n_rsp;
        rstn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) check("ready_after_rerelease", 32'(host_req_ready), 32'd1);
        end while (!clk_div && n < 50);
        check("first_div_after_reset", n, DIV);
        repeat (20) tick();
        check("no_rsp_after_reset", n_rsp, r0);

        // the bridge still works after the abort
        r0 = n_rsp;
        issue(1'b0, BASE + 32'h10, '0);
        wait_rsp(r0 + 1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/asa_pio_bridge.md
Name: asa_pio_bridge

Overview:
- Host-facing PIO master that sits directly upstream of the ASA register block. It drives that block's reg_bs/reg_rd/reg_wr/reg_addr/reg_din strobes and generates the clk_div enable.
- It collects pio_ack/pio_rvalid/pio_rdata and returns one response per host request.
- It handles address-window decode, one outstanding transaction, timeout and drain of sticky acks before the next request.

Parameters:
- PIO_NBITS, 32, width of address and data.
- REG_ADDR_NBITS, 8, low address bits passed through as the register offset; upper bits form the window compare.
- BASE_ADDR, 32'h0000_0400, block window base. Only bits [PIO_NBITS-1:REG_ADDR_NBITS] are compared.
- DIV, 4, clk_div period in clk cycles; minimum 2.
- TIMEOUT, 255, WAIT-state cycle limit before error completion; 8-bit counter.

Ports:
- clk  in  1  core clock
- rstn  in  1  async active-low reset
- host_req_valid  in  1  request present
- host_req_ready  out  1  bridge accepts request (IDLE only)
- host_req_wr  in  1  1=write, 0=read
- host_req_addr  in  PIO_NBITS  byte address
- host_req_wdata  in  PIO_NBITS  write data
- host_rsp_valid  out  1  one-cycle completion pulse
- host_rsp_err  out  1  completion was out-of-window or timeout
- host_rsp_rdata  out  PIO_NBITS  read data; 0 for writes/errors
- clk_div  out  1  one-cycle enable every DIV clocks
- reg_bs  out  1  block select
- reg_rd  out  1  read strobe
- reg_wr  out  1  write strobe
- reg_addr  out  PIO_NBITS  latched address
- reg_din  out  PIO_NBITS  latched write data
- pio_ack  in  1  write ack from register block (sticky until its next clk_div)
- pio_rvalid  in  1  read valid from register block (sticky until its next clk_div)
- pio_rdata  in  PIO_NBITS  read data, valid with pio_rvalid

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low, ports named clk and rstn. All outputs are registered.
- Reset values: every output is 0; state = IDLE; div counter = 0; timeout counter = 0. host_req_ready becomes 1 the first cycle after reset release.
- clk_div: free-running counter 0..DIV-1. clk_div=1 in the cycle after the counter equals DIV-1, i.e. every DIV cycles, and is independent of transactions. The first pulse occurs DIV cycles after reset release.
- IDLE: host_req_ready=1. On host_req_valid:
  - Latch addr/wdata/wr into reg_addr/reg_din.
  - If the window matches, go to REQ.
  - Otherwise go to ERR.
- ERR (1 cycle): host_rsp_valid=1, host_rsp_err=1, rdata=0, then IDLE. No reg_* strobe is issued.
- REQ (1 cycle):
  - reg_bs=1.
  - reg_wr=host_req_wr, or reg_rd=~host_req_wr. The strobe is exactly one cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - reg_bs is held 1, and reg_addr/reg_din stay stable.
  - A write completes on the first cycle pio_ack=1.
  - A read completes on the first cycle pio_rvalid=1; pio_rdata is captured that cycle.
  - Completion: host_rsp_valid=1 next cycle, err=0, rdata=captured (0 for write). Then go to DRAIN.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT with no completion: err=1, rdata=0, go to DRAIN.
  - Completion and timeout in the same cycle: completion wins.
- DRAIN:
  - reg_bs=0, reg_rd=reg_wr=0.
  - Stay until pio_ack=0 and pio_rvalid=0 are sampled in the same cycle, then go to IDLE.
  - This prevents a stale sticky ack completing the next request.
  - Exits in at most DIV+1 cycles after the last assertion.
- host_req_ready is 0 in every state except IDLE. Requests presented while not ready are not consumed; the host holds valid.
- host_rsp_rdata holds its value until the next completion.
- Window match: host_req_addr[PIO_NBITS-1:REG_ADDR_NBITS] == BASE_ADDR[PIO_NBITS-1:REG_ADDR_NBITS].
- Reset mid-operation: all state and strobes clear immediately (async). No response is issued for the aborted request.

Test Plan:
- Write 0x0000_1234 to BASE+0x00 -> one-cycle reg_wr with reg_bs=1 and reg_din=0x1234. host_rsp_valid with err=0 arrives within DIV+3 cycles. reg_bs drops and ready returns after pio_ack clears.
- Read BASE+0x00 after the write -> one-cycle reg_rd. host_rsp_rdata=0x0000_1234, err=0. reg_bs is held high until pio_rvalid=1.
- Write to 0x0000_0800 (outside window) -> no reg_bs/reg_wr ever. host_rsp_valid with err=1, rdata=0 two cycles after acceptance.
- Read with the slave stub never asserting ack/rvalid, TIMEOUT=16 -> err=1, rdata=0 after 16 WAIT cycles, then IDLE.
- Back-to-back write then read with host_req_valid held -> the second request is not accepted until pio_ack=0. Each request gets exactly one response, and the read is not completed by the stale ack.
- Assert rstn=0 during WAIT -> all outputs 0 immediately. After release there is no response pulse, and the first clk_div occurs DIV cycles later.
